// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset release sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package reset_seq_pkg;

  // Sequencer phases, in the order a clean power-up walks through them.
  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    GAP        = 3'd1,
    WAIT_READY = 3'd2,
    DONE       = 3'd3,
    FAULT      = 3'd4
  } seq_state_t;

  localparam int DEF_NUM_DOMAINS          = 4;
  localparam int DEF_LOCK_FILTER_CYCLES   = 16;
  localparam int DEF_GAP_CYCLES           = 8;
  localparam int DEF_READY_TIMEOUT_CYCLES = 1024;
  localparam int DEF_REQ_PULSE_CYCLES     = 4;

  // Width of a counter that must hold values 0..limit-1 with one spare bit.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

  // Width of an index over count items; never narrower than one bit.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Two-flop synchronizer with asynchronous clear, for resets or for plain level signals.
// Latency: 2 clk edges from input change to output change; clear acts immediately.
// Backpressure: none; it samples every edge.
module reset_synchronizer #(
  // 1: reset mode, shifts in a constant 1 so the output is a synchronously released reset.
  // 0: data mode, shifts in the sampled level.
  parameter bit RESET_MODE = 1'b0
) (
  input  logic clk,
  input  logic clear_n,
  input  logic sample,
  output logic synced
);

  logic [1:0] chain;
  logic       shift_value;

  assign shift_value = RESET_MODE ? 1'b1 : sample;

  // Two-stage capture; clearing drops both stages at once so assertion is not delayed.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      chain <= 2'b00;
    end else begin
      chain <= {chain[0], shift_value};
    end
  end

  assign synced = chain[1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Releases NUM_DOMAINS reset domains in index order once the PLL lock has been qualified.
// Latency: first release LOCK_FILTER_CYCLES+GAP_CYCLES edges after lock is seen past its 2-flop sync.
// Backpressure: each release waits for that domain's ready; lock loss restarts, a missing ready faults.
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS          = DEF_NUM_DOMAINS,
  parameter int LOCK_FILTER_CYCLES   = DEF_LOCK_FILTER_CYCLES,
  parameter int GAP_CYCLES           = DEF_GAP_CYCLES,
  parameter int READY_TIMEOUT_CYCLES = DEF_READY_TIMEOUT_CYCLES,
  parameter int REQ_PULSE_CYCLES     = DEF_REQ_PULSE_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 pll_locked,
  input  logic [NUM_DOMAINS-1:0]               domain_ready,
  output logic [NUM_DOMAINS-1:0]               domain_resetn,
  output logic                                 all_released,
  output logic                                 seq_error,
  output logic                                 reset_req_n,
  output logic [idx_width(NUM_DOMAINS)-1:0]    cur_domain
);

  localparam int IDX_W  = idx_width(NUM_DOMAINS);
  localparam int LOCK_W = cnt_width(LOCK_FILTER_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);
  localparam int TMO_W  = cnt_width(READY_TIMEOUT_CYCLES);
  localparam int REQ_W  = cnt_width(REQ_PULSE_CYCLES);

  // Terminal counts: each counter is compared against its last value and the state
  // exits on that edge, so no counter ever needs to wrap or saturate.
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(READY_TIMEOUT_CYCLES - 1);
  localparam logic [REQ_W-1:0]  REQ_LAST  = REQ_W'(REQ_PULSE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic                   rst_n;
  logic                   lock_s;
  logic [NUM_DOMAINS-1:0] rdy_s;

  seq_state_t             state;
  logic [LOCK_W-1:0]      lock_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [REQ_W-1:0]       req_cnt;
  logic                   lock_lost;

  // Internal reset: asserted with resetn, released two edges after it.
  reset_synchronizer #(.RESET_MODE(1'b1)) u_rst_sync (
    .clk     (clk),
    .clear_n (resetn),
    .sample  (1'b1),
    .synced  (rst_n)
  );

  // Lock and ready inputs are cleared by the raw reset so they already carry
  // valid samples by the time rst_n releases the sequencer.
  reset_synchronizer #(.RESET_MODE(1'b0)) u_lock_sync (
    .clk     (clk),
    .clear_n (resetn),
    .sample  (pll_locked),
    .synced  (lock_s)
  );

  for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_rdy_sync
    reset_synchronizer #(.RESET_MODE(1'b0)) u_rdy_sync (
      .clk     (clk),
      .clear_n (resetn),
      .sample  (domain_ready[k]),
      .synced  (rdy_s[k])
    );
  end

  // Lock loss only matters once sequencing has begun and before a fault latches.
  assign lock_lost = !lock_s && ((state == GAP) || (state == WAIT_READY) || (state == DONE));

  // Sequencer FSM; all outputs are registered here, and the async clear on rst_n
  // is what pulls every domain back into reset without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= WAIT_LOCK;
      lock_cnt      <= '0;
      gap_cnt       <= '0;
      tmo_cnt       <= '0;
      req_cnt       <= '0;
      domain_resetn <= '0;
      all_released  <= 1'b0;
      seq_error     <= 1'b0;
      reset_req_n   <= 1'b1;
      cur_domain    <= '0;
    end else if (lock_lost) begin
      // Checked ahead of ready and timeout so a lost clock always wins the edge.
      state         <= WAIT_LOCK;
      lock_cnt      <= '0;
      domain_resetn <= '0;
      all_released  <= 1'b0;
      cur_domain    <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (!lock_s) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            lock_cnt   <= '0;
            gap_cnt    <= '0;
            cur_domain <= '0;
            state      <= GAP;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            domain_resetn[cur_domain] <= 1'b1;
            tmo_cnt                   <= '0;
            state                     <= WAIT_READY;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        WAIT_READY: begin
          // Ready is tested before the timeout so a late-but-in-time ready still counts.
          if (rdy_s[cur_domain]) begin
            if (cur_domain == IDX_LAST) begin
              all_released <= 1'b1;
              state        <= DONE;
            end else begin
              cur_domain <= cur_domain + 1'b1;
              gap_cnt    <= '0;
              state      <= GAP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            domain_resetn <= '0;
            all_released  <= 1'b0;
            seq_error     <= 1'b1;
            reset_req_n   <= 1'b0;
            req_cnt       <= '0;
            state         <= FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        DONE: begin
          // Everything stays released; per-domain ready drops are deliberately ignored.
          state <= DONE;
        end

        FAULT: begin
          // Hold the upstream request low for the pulse length, then stay parked here.
          if (!reset_req_n) begin
            if (req_cnt == REQ_LAST) begin
              reset_req_n <= 1'b1;
            end else begin
              req_cnt <= req_cnt + 1'b1;
            end
          end
        end

        default: begin
          state         <= WAIT_LOCK;
          lock_cnt      <= '0;
          domain_resetn <= '0;
          all_released  <= 1'b0;
          cur_domain    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: scenario table, hand sequences and random runs.
// Latency: outputs sampled 1 ns after each rising edge against a timeline model.
// Backpressure: domain_ready is driven from per-domain delays after each release.
module tb_reset_release_sequencer;

  localparam int N     = 4;
  localparam int FILT  = 16;
  localparam int GAPC  = 8;
  localparam int TMO   = 1024;
  localparam int PULSE = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         pll_locked = 1'b0;
  logic [N-1:0] domain_ready = '0;
  logic [N-1:0] domain_resetn;
  logic         all_released;
  logic         seq_error;
  logic         reset_req_n;
  logic [1:0]   cur_domain;

  reset_release_sequencer dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_locked    (pll_locked),
    .domain_ready  (domain_ready),
    .domain_resetn (domain_resetn),
    .all_released  (all_released),
    .seq_error     (seq_error),
    .reset_req_n   (reset_req_n),
    .cur_domain    (cur_domain)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scenario record: stimulus (lock glitch edge, ready delay per domain, length)
  // and expected edge numbers (-1 = never) counted from the first edge with resetn=1.
  typedef struct {
    string name;
    int    glitch;
    int    d0, d1, d2, d3;
    int    len;
    int    r0, r1, r2, r3;
    int    done;
    int    fault;
    int    pulse;
  } vec_t;

  vec_t vecs[6];

  // ---------------- reference model: event timeline ----------------
  typedef enum int {P_LOCK, P_GAP, P_WAIT, P_DONE, P_FAULT} phase_t;
  int           ecount;
  phase_t       ph;
  int           run_start, release_at, timeout_at, fault_at;
  int           m_dom;
  logic [N-1:0] m_rel;
  logic         m_all, m_err;
  logic         q_lock[$];
  logic [N-1:0] q_rdy[$];

  task automatic model_reset();
    ecount = 0; ph = P_LOCK; run_start = -1; release_at = 0; timeout_at = 0;
    fault_at = -1000; m_dom = 0; m_rel = '0; m_all = 1'b0; m_err = 1'b0;
    q_lock = '{1'b0, 1'b0};
    q_rdy  = '{'0, '0};
  endtask

  function automatic logic m_req();
    return !(ecount >= fault_at && ecount < fault_at + PULSE);
  endfunction

  task automatic model_edge();
    logic lk;
    logic [N-1:0] rd;
    if (!resetn) return;
    ecount++;
    lk = q_lock.pop_front();
    rd = q_rdy.pop_front();
    q_lock.push_back(pll_locked);
    q_rdy.push_back(domain_ready);
    if (ecount < 3 || ph == P_FAULT) return;
    if (ph != P_LOCK && !lk) begin
      m_rel = '0; m_all = 1'b0; m_dom = 0; ph = P_LOCK; run_start = -1;
      return;
    end
    case (ph)
      P_LOCK: begin
        if (!lk) run_start = -1;
        else begin
          if (run_start < 0) run_start = ecount;
          if (ecount - run_start + 1 == FILT) begin
            ph = P_GAP; m_dom = 0; release_at = ecount + GAPC;
          end
        end
      end
      P_GAP: if (ecount == release_at) begin
        m_rel[m_dom] = 1'b1; ph = P_WAIT; timeout_at = ecount + TMO;
      end
      P_WAIT: begin
        if (rd[m_dom]) begin
          if (m_dom == N - 1) begin ph = P_DONE; m_all = 1'b1; end
          else begin m_dom++; ph = P_GAP; release_at = ecount + GAPC; end
        end else if (ecount == timeout_at) begin
          ph = P_FAULT; m_rel = '0; m_all = 1'b0; m_err = 1'b1; fault_at = ecount;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus / observation state ----------------
  int           lock_mode;     // 0: table glitch, 1: manual, 2: random
  int           glitch;
  int           lock_off_left;
  int           dly[N];
  int           rel_edge[N];
  int           rel_last[N];
  int           done_edge, fault_edge, pulse_len;
  logic [N-1:0] kill;

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    logic [N+4:0] got, want;
    @(posedge clk);
    model_edge();
    #1;
    got  = {domain_resetn, all_released, seq_error, reset_req_n, cur_domain};
    want = {m_rel, m_all, m_err, m_req(), 2'(m_dom)};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL cycle edge=%0d got=%b want=%b (resetn,all,err,req_n,dom)", ecount, got, want);
    end
    for (int k = 0; k < N; k++) begin
      if (domain_resetn[k] && rel_edge[k] < 0) begin
        rel_edge[k] = ecount;
        rel_last[k] = ecount;
      end
      if (!domain_resetn[k]) rel_edge[k] = -1;
    end
    if (all_released && done_edge < 0) done_edge = ecount;
    if (seq_error && fault_edge < 0) fault_edge = ecount;
    if (!reset_req_n) pulse_len++;
    if (lock_mode == 0) begin
      pll_locked = (ecount + 1 != glitch);
    end else if (lock_mode == 2) begin
      if (lock_off_left > 0) begin
        lock_off_left--; pll_locked = 1'b0;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 199) == 0) lock_off_left = $urandom_range(1, 4);
      end
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 63) == 0) kill[k] = ~kill[k];
    end
    for (int k = 0; k < N; k++)
      domain_ready[k] = (rel_edge[k] >= 0) && (dly[k] >= 0) &&
                        (ecount + 1 >= rel_edge[k] + dly[k]) && !kill[k];
  endtask

  task automatic start_vec(input vec_t v);
    resetn = 1'b0;
    model_reset();
    lock_mode = 0; glitch = v.glitch; lock_off_left = 0;
    pll_locked = 1'b1; domain_ready = '0; kill = '0;
    dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2; dly[3] = v.d3;
    for (int k = 0; k < N; k++) begin rel_edge[k] = -1; rel_last[k] = -1; end
    done_edge = -1; fault_edge = -1; pulse_len = 0;
    repeat (3) step();
    resetn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    start_vec(v);
    repeat (v.len) step();
    check_int({v.name, " rel0"}, rel_last[0], v.r0);
    check_int({v.name, " rel1"}, rel_last[1], v.r1);
    check_int({v.name, " rel2"}, rel_last[2], v.r2);
    check_int({v.name, " rel3"}, rel_last[3], v.r3);
    check_int({v.name, " done"}, done_edge, v.done);
    check_int({v.name, " fault"}, fault_edge, v.fault);
    check_int({v.name, " req pulse"}, pulse_len, v.pulse);
  endtask

  initial begin
    int e0;
    vec_t rv;
    vecs[0] = '{"full sequence",        0, 5, 5, 5, 5,     90,   26, 41, 56, 71,     78,   -1, 0};
    vecs[1] = '{"lock glitch",         11, 5, 5, 5, 5,    100,   37, 52, 67, 82,     89,   -1, 0};
    vecs[2] = '{"timeout dom2",         0, 5, 5, -1, 5,  1100,   26, 41, 56, -1,     -1, 1080, 4};
    vecs[3] = '{"ready on timeout",     0, 5, 1022, 5, 5, 1110,  26, 41, 1073, 1088, 1095, -1, 0};
    vecs[4] = '{"ready one late",       0, 5, 1023, 5, 5, 1080,  26, 41, -1, -1,     -1, 1065, 4};
    vecs[5] = '{"lock loss vs ready",  31, 5, 5, 5, 5,    120,   57, 72, 87, 102,   109,   -1, 0};

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Fault is terminal: lock loss must not disturb it.
    run_vec(vecs[2]);
    lock_mode = 1;
    pll_locked = 1'b0;
    repeat (10) step();
    check_int("fault sticky err", int'(seq_error), 1);
    check_int("fault dom held", int'(domain_resetn), 0);
    check_int("fault cur_domain", int'(cur_domain), 2);

    // Lock loss in DONE: everything back in reset within 3 edges, then replay.
    run_vec(vecs[0]);
    check_int("done all_released", int'(all_released), 1);
    lock_mode = 1;
    pll_locked = 1'b0;
    e0 = ecount;
    repeat (3) step();
    check_int("lockloss dom_resetn", int'(domain_resetn), 0);
    check_int("lockloss all_released", int'(all_released), 0);
    pll_locked = 1'b1;
    repeat (50) step();
    check_int("relock rel0", rel_last[0], e0 + 29);
    check_int("relock rel1", rel_last[1], e0 + 44);

    // Async reset between edges while in GAP with domain 0 released.
    start_vec(vecs[0]);
    repeat (36) step();
    check_int("pre-async dom0", int'(domain_resetn[0]), 1);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_int("async dom_resetn", int'(domain_resetn), 0);
    check_int("async req_n", int'(reset_req_n), 1);
    check_int("async cur_domain", int'(cur_domain), 0);
    run_vec(vecs[0]);

    // Randomized ready delays, lock drops and ready flicker against the model.
    for (int r = 0; r < 6; r++) begin
      rv = vecs[0];
      rv.d0 = $urandom_range(1, 15); rv.d1 = $urandom_range(1, 15);
      rv.d2 = $urandom_range(1, 15); rv.d3 = $urandom_range(1, 15);
      start_vec(rv);
      lock_mode = 2;
      repeat (600) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
Name: reset_release_sequencer

Overview:
- Consumes the global active-low reset and a PLL lock indication.
- Releases NUM_DOMAINS downstream reset domains one at a time, in index order, with a fixed gap between releases.
- Waits for each domain's ready acknowledgment before releasing the next domain.
- On lock loss or a missing acknowledgment, re-asserts all domain resets. It can also pulse a reset request back into the upstream reset-source network.

Parameters:
- NUM_DOMAINS, 4: number of sequenced reset domains (1..16).
- LOCK_FILTER_CYCLES, 16: consecutive synchronized pll_locked=1 samples required before sequencing starts (>=1).
- GAP_CYCLES, 8: clocks between qualification (or the previous domain's ready) and the next release (>=1).
- READY_TIMEOUT_CYCLES, 1024: maximum clocks to wait for domain_ready[k] after releasing domain k.
- REQ_PULSE_CYCLES, 4: length of the low pulse on reset_req_n when a fault occurs (>=2).

Ports:
- clk  in  1  system clock.
- resetn  in  1  global reset; asynchronous, active-low.
- pll_locked  in  1  PLL lock status; asynchronous to clk.
- domain_ready  in  NUM_DOMAINS  per-domain "out of reset" acknowledgment; asynchronous to clk.
- domain_resetn  out  NUM_DOMAINS  per-domain active-low reset; each domain re-synchronizes it locally.
- all_released  out  1  high while every domain is released and the sequencer is in DONE.
- seq_error  out  1  sticky timeout flag.
- reset_req_n  out  1  active-low reset request to the upstream reset generator.
- cur_domain  out  clog2(NUM_DOMAINS) (min 1)  index of the domain being sequenced.

Behaviour:
Reset and synchronization:
- resetn is asserted asynchronously and deasserted synchronously through a 2-flop reset synchronizer, giving internal rst_n.
- While rst_n=0: domain_resetn=0 (all bits, asynchronously), all_released=0, seq_error=0, reset_req_n=1, cur_domain=0, state=WAIT_LOCK, all counters=0.
- pll_locked and each domain_ready bit pass through 2-flop synchronizers (reset to 0), giving lock_s and rdy_s[k].

States and transitions:
- WAIT_LOCK
  - lock_cnt increments on each edge with lock_s=1 and clears to 0 on lock_s=0.
  - At the edge where the LOCK_FILTER_CYCLES-th consecutive sample is taken: state goes to GAP, gap_cnt=0, cur_domain=0.
- GAP
  - gap_cnt increments each edge.
  - At the GAP_CYCLES-th edge: domain_resetn[cur_domain] is set to 1, tmo_cnt=0, state goes to WAIT_READY.
- WAIT_READY
  - If rdy_s[cur_domain]=1 and cur_domain=NUM_DOMAINS-1: state goes to DONE and all_released becomes 1 on the same edge.
  - Else if rdy_s[cur_domain]=1: cur_domain increments, gap_cnt=0, state goes to GAP.
  - Else tmo_cnt increments. At tmo_cnt=READY_TIMEOUT_CYCLES-1: state goes to FAULT.
- DONE
  - Holds all domain resets released.
  - A domain dropping ready in DONE is ignored.
- FAULT
  - On entry: domain_resetn=0 (all), all_released=0, seq_error=1.
  - reset_req_n is driven 0 for exactly REQ_PULSE_CYCLES clocks, then returns to 1.
  - The state is terminal until rst_n is asserted.

Lock loss:
- lock_s=0 in GAP, WAIT_READY or DONE forces, on the next edge: domain_resetn=0 (all), all_released=0, cur_domain=0, lock_cnt=0, state=WAIT_LOCK. Sequencing then restarts from domain 0.
- Lock loss in FAULT is ignored.

Priorities within one edge:
- Lock loss beats ready and beats timeout.
- Ready beats timeout.

Other rules:
- Released domains stay released while later domains sequence.
- Outputs are registered, except for the asynchronous assertion of domain_resetn.
- Counters are saturating-free and sized to clog2 of their limit plus 1. They never wrap, because each state exits at its limit.
- resetn assertion mid-sequence returns every output to its reset value immediately.

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum {WAIT_LOCK, GAP, WAIT_READY, DONE, FAULT};
  - the default parameter constants;
  - a clog2-based width helper.
- Sub-module reset_synchronizer: 2-flop chain with async clear, parameterized reset-assert or data mode. It is used for rst_n, lock_s and each rdy_s bit.

Test Plan:
Timing in the first scenario is counted in clk edges from the first edge that samples resetn=1.
1. Full default sequence:
   - Stimulus: pll_locked=1 held before reset release; ready[k] raised 5 cycles after domain_resetn[k] rises.
   - Response: domain_resetn[0] rises at edge 26.
   - Each subsequent domain rises 5+2+8=15 edges after the previous one; all_released=1 two edges after ready[3] rises.
   - seq_error=0 and reset_req_n=1 throughout.
2. Lock glitch during qualification:
   - Stimulus: pll_locked drops for 1 cycle after 10 samples.
   - Response: lock_cnt restarts; domain_resetn[0] is delayed by the full 16+8 cycles counted from relock.
3. Lock loss in DONE:
   - Stimulus: pll_locked=0.
   - Response: within 3 edges (2 sync + 1), all domain_resetn=0 and all_released=0; the sequence replays from domain 0 after relock.
4. Timeout:
   - Stimulus: domain_ready[2] never asserted.
   - Response: FAULT exactly 1024 edges after domain_resetn[2] rises; all domain_resetn=0; seq_error=1 (sticky); reset_req_n low exactly 4 cycles.
   - Only resetn clears the fault.
5. Simultaneous events:
   - Ready arriving on the timeout edge: ready wins, sequencing proceeds.
   - Lock loss on the same edge as ready: WAIT_LOCK wins.
6. Async reset mid-GAP:
   - Stimulus: assert resetn between clock edges.
   - Response: domain_resetn=0 with no clock edge; after release, the full timing of scenario 1 repeats.
